// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel pipeline blocks.
// Index widths are clog2-based and never drop below one bit.
package sobel_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_LINE_WIDTH   = 640;
  localparam int DEFAULT_FRAME_HEIGHT = 480;
  localparam int DEFAULT_NUM_TAPS     = 3;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // LSB position of tap slice k inside a packed column of pixels.
  function automatic int tap_lsb(input int k, input int data_width);
    return k * data_width;
  endfunction

endpackage

// File: rtl/line_ram_delay.sv
// One line of pixel storage: asynchronous read and write-on-enable at the same address.
// The read therefore returns the previous line's pixel before this edge overwrites it.
module line_ram_delay
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int ADDR_WIDTH = idx_width(LINE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [LINE_WIDTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_tap_buffer.sv
// Multi-line delay that presents a vertical column of NUM_TAPS same-column pixels per accepted pixel.
// Optional macro BORDER_REPLICATE_EN replicates the oldest valid line on the first rows of a frame.
module line_tap_buffer
  import sobel_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter  int LINE_WIDTH   = DEFAULT_LINE_WIDTH,
  parameter  int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter  int NUM_TAPS     = DEFAULT_NUM_TAPS,
  localparam int COL_W        = idx_width(LINE_WIDTH),
  localparam int ROW_W        = idx_width(FRAME_HEIGHT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           data_valid,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] taps_out,
  output logic                           taps_valid,
  output logic [COL_W-1:0]               col_out,
  output logic [ROW_W-1:0]               row_out,
  output logic                           eol_out,
  output logic                           eof_out
);

  localparam int               FILL_W   = idx_width(NUM_TAPS);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_TAPS - 1);

  logic [COL_W-1:0]               col_q;
  logic [ROW_W-1:0]               row_q;
  logic [FILL_W-1:0]              fill_q;
  logic [DATA_WIDTH-1:0]          line_px [NUM_TAPS];
  logic [NUM_TAPS*DATA_WIDTH-1:0] taps_next;
  logic                           valid_next;
  logic                           accept;
  logic                           col_last;
  logic                           row_last;

  assign accept     = data_valid & ~rst;
  assign col_last   = (col_q == COL_W'(LINE_WIDTH - 1));
  assign row_last   = (row_q == ROW_W'(FRAME_HEIGHT - 1));
  assign line_px[0] = data_in;

  // Memories form a chain: each one shifts the line it holds one step older.
  for (genvar k = 1; k < NUM_TAPS; k++) begin : g_line
    line_ram_delay #(
      .DATA_WIDTH(DATA_WIDTH),
      .LINE_WIDTH(LINE_WIDTH),
      .ADDR_WIDTH(COL_W)
    ) u_ram (
      .clk  (clk),
      .we   (accept),
      .addr (col_q),
      .wdata(line_px[k-1]),
      .rdata(line_px[k])
    );
  end

  always_comb begin
    taps_next = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
`ifdef BORDER_REPLICATE_EN
      taps_next[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
        (k > int'(fill_q)) ? line_px[fill_q] : line_px[k];
`else
      taps_next[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = line_px[k];
`endif
    end
`ifdef BORDER_REPLICATE_EN
    valid_next = 1'b1;
`else
    valid_next = (fill_q == FILL_MAX);
`endif
  end

  // Fill count masks stale memory contents; it restarts on every new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      fill_q     <= '0;
      taps_out   <= '0;
      taps_valid <= 1'b0;
      col_out    <= '0;
      row_out    <= '0;
      eol_out    <= 1'b0;
      eof_out    <= 1'b0;
    end else if (data_valid) begin
      taps_out   <= taps_next;
      taps_valid <= valid_next;
      col_out    <= col_q;
      row_out    <= row_q;
      eol_out    <= col_last;
      eof_out    <= col_last && row_last;
      if (col_last) begin
        col_q <= '0;
        if (row_last) begin
          row_q  <= '0;
          fill_q <= '0;
        end else begin
          row_q <= row_q + 1'b1;
          if (fill_q != FILL_MAX) begin
            fill_q <= fill_q + 1'b1;
          end
        end
      end else begin
        col_q <= col_q + 1'b1;
      end
    end else begin
      taps_valid <= 1'b0;
      eol_out    <= 1'b0;
      eof_out    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_tap_buffer.sv
// Directed bench for line_tap_buffer with a small 10x5 frame and three taps.
// Honours BORDER_REPLICATE_EN when it is defined for the build.
module tb_line_tap_buffer;

  localparam int DW = 6;
  localparam int LW = 10;
  localparam int FH = 5;
  localparam int NT = 3;
`ifdef BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     data_in;
  logic              data_valid;
  logic [NT*DW-1:0]  taps_out;
  logic              taps_valid;
  logic [3:0]        col_out;
  logic [2:0]        row_out;
  logic              eol_out;
  logic              eof_out;

  always #5 clk = ~clk;

  line_tap_buffer #(
    .DATA_WIDTH(DW),
    .LINE_WIDTH(LW),
    .FRAME_HEIGHT(FH),
    .NUM_TAPS(NT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .taps_out  (taps_out),
    .taps_valid(taps_valid),
    .col_out   (col_out),
    .row_out   (row_out),
    .eol_out   (eol_out),
    .eof_out   (eof_out)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: every pixel of the current frame, indexed by row and column.
  logic [DW-1:0]    model [FH][LW];
  int               mrow, mcol;
  logic [NT*DW-1:0] expTaps;
  logic             expValid, expEol, expEof, tapsKnown;
  int               expCol, expRow;
  int               eofCount, validCount;

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(c + 10 * r);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] din, input logic dv, input logic rs);
    int srow;
    data_in    = din;
    data_valid = dv;
    rst        = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      expTaps = '0; expValid = 1'b0; expCol = 0; expRow = 0;
      expEol = 1'b0; expEof = 1'b0; mrow = 0; mcol = 0; tapsKnown = 1'b1;
    end else if (dv) begin
      model[mrow][mcol] = din;
      expValid = BORDER ? 1'b1 : (mrow >= NT - 1);
      for (int k = 0; k < NT; k++) begin
        srow = mrow - k;
        if (srow < 0) srow = 0;
        expTaps[k*DW +: DW] = model[srow][mcol];
      end
      expCol = mcol;
      expRow = mrow;
      expEol = (mcol == LW - 1);
      expEof = expEol && (mrow == FH - 1);
      tapsKnown = expValid;
      if (mcol == LW - 1) begin
        mcol = 0;
        mrow = (mrow == FH - 1) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
    end else begin
      expValid = 1'b0; expEol = 1'b0; expEof = 1'b0;
    end
    checkOutput("taps_valid", taps_valid, expValid);
    checkOutput("col_out", col_out, expCol);
    checkOutput("row_out", row_out, expRow);
    checkOutput("eol_out", eol_out, expEol);
    checkOutput("eof_out", eof_out, expEof);
    if (tapsKnown) checkOutput("taps_out", taps_out, expTaps);
    if (eof_out) eofCount++;
    if (taps_valid) validCount++;
  endtask

  initial begin
    logic [NT*DW-1:0] spot;
    logic [31:0]      pat;
    int               acc, cyc;
    rst = 1'b1; data_valid = 1'b0; data_in = '0;
    mrow = 0; mcol = 0; tapsKnown = 1'b0; eofCount = 0; validCount = 0;

    $display("[TB] reset");
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("reset_taps", taps_out, 0);

    $display("[TB] frame 1 continuous");
    for (int r = 0; r < FH; r++) begin
      for (int c = 0; c < LW; c++) begin
        applyStimulus(pix(r, c), 1'b1, 1'b0);
        if (r == 0 && c == 0) begin
          checkOutput("px0_valid", taps_valid, BORDER);
          if (BORDER) checkOutput("px0_taps", taps_out, 0);
        end
        if (r == 1 && c == 3 && BORDER) begin
          spot = {6'd3, 6'd3, 6'd13};
          checkOutput("px13_taps", taps_out, spot);
        end
        if (r == 1 && c == 9) checkOutput("px19_valid", taps_valid, BORDER);
        if (r == 2 && c == 0) begin
          spot = {6'd0, 6'd10, 6'd20};
          checkOutput("px20_valid", taps_valid, 1);
          checkOutput("px20_taps", taps_out, spot);
        end
        if (r == 2 && c == 5) begin
          spot = {6'd5, 6'd15, 6'd25};
          checkOutput("px25_taps", taps_out, spot);
        end
        if (r == 4 && c == 7) begin
          spot = {6'd27, 6'd37, 6'd47};
          checkOutput("px47_taps", taps_out, spot);
        end
      end
    end

    $display("[TB] frame 2 back to back");
    eofCount = 0;
    for (int r = 0; r < FH; r++) begin
      for (int c = 0; c < LW; c++) begin
        applyStimulus(pix(r, c), 1'b1, 1'b0);
        if (r == 0 && c == 0) checkOutput("f2_px0_valid", taps_valid, BORDER);
        if (r == 1 && c == 9) checkOutput("f2_px19_valid", taps_valid, BORDER);
        if (r == 2 && c == 0) begin
          spot = {6'd0, 6'd10, 6'd20};
          checkOutput("f2_px20_taps", taps_out, spot);
        end
        if (r == 4 && c == 8) checkOutput("f2_px48_eof", eof_out, 0);
        if (r == 4 && c == 9) begin
          checkOutput("f2_px49_eof", eof_out, 1);
          checkOutput("f2_px49_eol", eol_out, 1);
        end
      end
    end
    checkOutput("f2_eof_count", eofCount, 1);

    $display("[TB] frame 3 with stalls");
    pat = 32'hB3A5_6C1D;
    acc = 0;
    cyc = 0;
    while (acc < LW * FH && cyc < 400) begin
      if (pat[cyc % 32]) begin
        applyStimulus(pix(mrow, mcol), 1'b1, 1'b0);
        acc++;
      end else begin
        applyStimulus('1, 1'b0, 1'b0);
      end
      cyc++;
    end
    checkOutput("stall_accepted", acc, LW * FH);

    $display("[TB] reset mid-frame");
    while (!(mrow == 3 && mcol == 4)) applyStimulus(pix(mrow, mcol), 1'b1, 1'b0);
    applyStimulus(pix(3, 4), 1'b1, 1'b1);
    checkOutput("rst_mid_valid", taps_valid, 0);
    checkOutput("rst_mid_taps", taps_out, 0);
    applyStimulus(pix(0, 0), 1'b1, 1'b0);
    checkOutput("post_rst_col", col_out, 0);
    checkOutput("post_rst_row", row_out, 0);
    validCount = 0;
    for (int i = 1; i < 20; i++) applyStimulus(pix(mrow, mcol), 1'b1, 1'b0);
    checkOutput("post_rst_valid_count", validCount, BORDER ? 19 : 0);
    for (int i = 0; i < 30; i++) applyStimulus(pix(mrow, mcol), 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
